// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle controller: opcodes, functs, ALU codes,
// FSM state encoding, instruction classes and PC source codes.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLTZ  = 6'b000110;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_BEQ  = 4'b1000;
    localparam logic [3:0] ALU_BNE  = 4'b1001;
    localparam logic [3:0] ALU_BLTZ = 4'b1010;

    localparam logic [1:0] PCSRC_SEQ    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [2:0] {
        S_IF, S_ID, S_EXE, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_BLTZ, C_J, C_HALT
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: classifies op/funct and produces the
// datapath selects that stay fixed for the whole instruction.
module mc_decode
    import mc_pkg::*;
#(
    parameter int ALUOP_W = 4
)
(
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    output iclass_t            iclass,
    output logic [ALUOP_W-1:0] aluop,
    output logic               alusrca,
    output logic               alusrcb,
    output logic               regdst,
    output logic               extsel,
    output logic               datasrc
);

    logic [3:0] code;

    always_comb begin
        iclass  = C_NOP;
        code    = ALU_AND;
        alusrca = 1'b0;
        alusrcb = 1'b0;
        regdst  = 1'b0;
        extsel  = 1'b0;
        datasrc = 1'b0;
        case (op)
            OP_RTYPE: begin
                iclass = C_ALU;
                regdst = 1'b1;
                case (funct)
                    FN_SLL: begin code = ALU_SLL; alusrca = 1'b1; end
                    FN_ADD: code = ALU_ADD;
                    FN_SUB: code = ALU_SUB;
                    FN_AND: code = ALU_AND;
                    FN_OR:  code = ALU_OR;
                    default: begin iclass = C_NOP; regdst = 1'b0; end
                endcase
            end
            OP_ADDIU: begin iclass = C_ALU; code = ALU_ADD; alusrcb = 1'b1; extsel = 1'b1; end
            OP_ANDI:  begin iclass = C_ALU; code = ALU_AND; alusrcb = 1'b1; end
            OP_ORI:   begin iclass = C_ALU; code = ALU_OR;  alusrcb = 1'b1; end
            OP_SLTI:  begin iclass = C_ALU; code = ALU_SLT; alusrcb = 1'b1; extsel = 1'b1; end
            OP_LW:    begin iclass = C_LW; code = ALU_ADD; alusrcb = 1'b1; extsel = 1'b1; datasrc = 1'b1; end
            OP_SW:    begin iclass = C_SW; code = ALU_ADD; alusrcb = 1'b1; extsel = 1'b1; end
            OP_BEQ:   begin iclass = C_BEQ;  code = ALU_BEQ;  end
            OP_BNE:   begin iclass = C_BNE;  code = ALU_BNE;  end
            OP_BLTZ:  begin iclass = C_BLTZ; code = ALU_BLTZ; end
            OP_J:     iclass = C_J;
            OP_HALT:  iclass = C_HALT;
            default:  iclass = C_NOP;
        endcase
        aluop = ALUOP_W'(code);
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU sequencer: IF/ID/EXE/MEM/WB FSM with memory ready handshakes,
// per-cycle enable generation and a retired-instruction counter.
module multi_cycle_control
    import mc_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int ALUOP_W = 4
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               sign,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic [1:0]         pcsrc,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               ALUsrcA,
    output logic               ALUsrcB,
    output logic               RegDst,
    output logic               ExtSel,
    output logic               datasrc,
    output logic               Regwrite,
    output logic               mWR,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
);

    state_t             state;
    iclass_t            iclass;
    logic [ALUOP_W-1:0] dec_aluop;
    logic               dec_alusrca, dec_alusrcb, dec_regdst, dec_extsel, dec_datasrc;
    logic               is_branch;
    logic               retire;

    mc_decode #(.ALUOP_W(ALUOP_W)) u_decode (
        .op      (op),
        .funct   (funct),
        .iclass  (iclass),
        .aluop   (dec_aluop),
        .alusrca (dec_alusrca),
        .alusrcb (dec_alusrcb),
        .regdst  (dec_regdst),
        .extsel  (dec_extsel),
        .datasrc (dec_datasrc)
    );

    assign is_branch = (iclass == C_BEQ) || (iclass == C_BNE) || (iclass == C_BLTZ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IF;
            instr_count <= '0;
        end else begin
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
            case (state)
                S_IF:  if (imem_ready) state <= S_ID;
                S_ID: begin
                    case (iclass)
                        C_J, C_NOP: state <= S_IF;
                        C_HALT:     state <= S_HALT;
                        default:    state <= S_EXE;
                    endcase
                end
                S_EXE: begin
                    if (is_branch)
                        state <= S_IF;
                    else if ((iclass == C_LW) || (iclass == C_SW))
                        state <= S_MEM;
                    else
                        state <= S_WB;
                end
                S_MEM: if (dmem_ready) state <= (iclass == C_SW) ? S_IF : S_WB;
                S_WB:   state <= S_IF;
                S_HALT: state <= S_HALT;
                default: state <= S_IF;
            endcase
        end
    end

    // Enables depend on same-cycle ready/flag inputs, so they are decoded from
    // state combinationally; reset forces every output low immediately.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        pcsrc    = PCSRC_SEQ;
        Regwrite = 1'b0;
        mWR      = 1'b0;
        halted   = 1'b0;
        retire   = 1'b0;
        ALUop    = '0;
        ALUsrcA  = 1'b0;
        ALUsrcB  = 1'b0;
        RegDst   = 1'b0;
        ExtSel   = 1'b0;
        datasrc  = 1'b0;
        if (state inside {S_ID, S_EXE, S_MEM, S_WB}) begin
            ALUop   = dec_aluop;
            ALUsrcA = dec_alusrca;
            ALUsrcB = dec_alusrcb;
            RegDst  = dec_regdst;
            ExtSel  = dec_extsel;
            datasrc = dec_datasrc;
            if (is_branch)
                pcsrc = PCSRC_BRANCH;
            else if (iclass == C_J)
                pcsrc = PCSRC_JUMP;
        end
        case (state)
            S_IF: begin
                imem_req = 1'b1;
                IRWrite  = imem_ready;
                PCWrite  = imem_ready;
            end
            S_ID: begin
                PCWrite = (iclass == C_J);
                retire  = (iclass == C_J) || (iclass == C_NOP);
            end
            S_EXE: begin
                case (iclass)
                    C_BEQ:   PCWrite = zero;
                    C_BNE:   PCWrite = ~zero;
                    C_BLTZ:  PCWrite = sign;
                    default: PCWrite = 1'b0;
                endcase
                retire = is_branch;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                mWR      = (iclass == C_SW);
                retire   = dmem_ready && (iclass == C_SW);
            end
            S_WB: begin
                Regwrite = 1'b1;
                retire   = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
        if (rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            pcsrc    = PCSRC_SEQ;
            Regwrite = 1'b0;
            mWR      = 1'b0;
            halted   = 1'b0;
            ALUop    = '0;
            ALUsrcA  = 1'b0;
            ALUsrcB  = 1'b0;
            RegDst   = 1'b0;
            ExtSel   = 1'b0;
            datasrc  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized bench for multi_cycle_control: each instruction is compared
// against an instruction-level model of cycle count, enable pulses and selects.
module tb_multi_cycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op, funct;
    logic        zero, sign, imem_ready, dmem_ready;
    logic        imem_req, dmem_req, PCWrite, IRWrite, Regwrite, mWR, halted;
    logic [1:0]  pcsrc;
    logic [3:0]  ALUop;
    logic        ALUsrcA, ALUsrcB, RegDst, ExtSel, datasrc;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;
    int modelCount = 0;

    typedef struct {
        int         cycles;
        int         pcw;
        logic [1:0] takenSrc;
        int         rw;
        int         dreq;
        int         mwr;
        logic [8:0] sel;
        bit         retire;
    } exp_t;

    multi_cycle_control #(.CNT_W(32), .ALUOP_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .sign(sign),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .pcsrc(pcsrc), .ALUop(ALUop), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
        .RegDst(RegDst), .ExtSel(ExtSel), .datasrc(datasrc), .Regwrite(Regwrite),
        .mWR(mWR), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Instruction-level reference: what one instruction should cost and show.
    function automatic exp_t expectFor(input logic [5:0] iop, input logic [5:0] ifn,
                                       input logic iz, input logic is, input int iw, input int dw);
        exp_t e;
        int kind;
        logic [3:0] alu;
        logic a, b, rd, ext, ds, taken;
        kind = 0; alu = 4'd0; a = 0; b = 0; rd = 0; ext = 0; ds = 0; taken = 0;
        case (iop)
            6'd0: begin
                kind = 1; rd = 1;
                case (ifn)
                    6'd0:  begin alu = 4'b0111; a = 1; end
                    6'd32: alu = 4'b0100;
                    6'd34: alu = 4'b0101;
                    6'd36: alu = 4'b0000;
                    6'd37: alu = 4'b0001;
                    default: begin kind = 0; rd = 0; end
                endcase
            end
            6'd9:  begin kind = 1; alu = 4'b0100; b = 1; ext = 1; end
            6'd12: begin kind = 1; alu = 4'b0000; b = 1; end
            6'd13: begin kind = 1; alu = 4'b0001; b = 1; end
            6'd10: begin kind = 1; alu = 4'b0110; b = 1; ext = 1; end
            6'd35: begin kind = 2; alu = 4'b0100; b = 1; ext = 1; ds = 1; end
            6'd43: begin kind = 3; alu = 4'b0100; b = 1; ext = 1; end
            6'd4:  begin kind = 4; alu = 4'b1000; taken = iz; end
            6'd5:  begin kind = 4; alu = 4'b1001; taken = !iz; end
            6'd6:  begin kind = 4; alu = 4'b1010; taken = is; end
            6'd2:  begin kind = 5; taken = 1; end
            default: kind = 0;
        endcase
        e.cycles = iw + 2;
        case (kind)
            1: e.cycles += 2;
            2: e.cycles += dw + 3;
            3: e.cycles += dw + 2;
            4: e.cycles += 1;
            default: ;
        endcase
        e.pcw      = 1 + int'(taken);
        e.takenSrc = (kind == 5) ? 2'd2 : 2'd1;
        e.rw       = (kind == 1 || kind == 2) ? 1 : 0;
        e.dreq     = (kind == 2 || kind == 3) ? dw + 1 : 0;
        e.mwr      = (kind == 3) ? dw + 1 : 0;
        e.sel      = {alu, a, b, rd, ext, ds};
        e.retire   = 1'b1;
        return e;
    endfunction

    // Runs one instruction starting at a sample point in its IF cycle; returns
    // at the sample point of the next IF.
    task automatic applyStimulus(input logic [5:0] iop, input logic [5:0] ifn,
                                 input logic iz, input logic is, input int iw, input int dw);
        exp_t e;
        int cyc = 0, irw = 0, pcw = 0, rw = 0, dreq = 0, mwr = 0, ireq = 0, iLeft = iw, dLeft = dw;
        bit leftIf = 0, selSeen = 0, selChanged = 0, timedOut = 0, anyHalt = 0;
        logic [1:0] fetchSrc = 2'd0, takenSrc = 2'd0;
        logic [8:0] firstSel = '0, lastSel = '0, curSel;
        e = expectFor(iop, ifn, iz, is, iw, dw);
        op = iop; funct = ifn; zero = iz; sign = is;
        forever begin
            if (cyc > 200) begin timedOut = 1; break; end
            if (imem_req && leftIf) break;
            if (!imem_req) leftIf = 1;
            imem_ready = imem_req ? (iLeft == 0) : 1'($urandom);
            dmem_ready = dmem_req ? (dLeft == 0) : 1'($urandom);
            #1;
            cyc++;
            irw += int'(IRWrite); rw += int'(Regwrite); dreq += int'(dmem_req);
            mwr += int'(mWR); ireq += int'(imem_req); pcw += int'(PCWrite);
            if (halted) anyHalt = 1;
            if (IRWrite) fetchSrc = pcsrc;
            else if (PCWrite) takenSrc = pcsrc;
            curSel = {ALUop, ALUsrcA, ALUsrcB, RegDst, ExtSel, datasrc};
            if (!imem_req) begin
                if (!selSeen) begin firstSel = curSel; selSeen = 1; end
                else if (curSel != firstSel) selChanged = 1;
                lastSel = curSel;
            end
            if (imem_req && iLeft > 0) iLeft--;
            if (dmem_req && dLeft > 0) dLeft--;
            @(negedge clk); #1;
        end
        checkOutput("timeout", timedOut, 0);
        checkOutput("cycles", cyc, e.cycles);
        checkOutput("imem_req_cycles", ireq, iw + 1);
        checkOutput("irwrite", irw, 1);
        checkOutput("fetch_pcsrc", fetchSrc, 2'd0);
        checkOutput("pcwrite", pcw, e.pcw);
        if (e.pcw == 2) checkOutput("taken_pcsrc", takenSrc, e.takenSrc);
        checkOutput("regwrite", rw, e.rw);
        checkOutput("dmem_req", dreq, e.dreq);
        checkOutput("mwr", mwr, e.mwr);
        checkOutput("selects", lastSel, e.sel);
        checkOutput("sel_stable", selChanged, 0);
        checkOutput("halted", anyHalt, 0);
        if (e.retire) modelCount++;
        checkOutput("instr_count", instr_count, modelCount);
    endtask

    logic [5:0] opList [0:13] = '{6'd0, 6'd0, 6'd0, 6'd2, 6'd4, 6'd5, 6'd6, 6'd9,
                                  6'd10, 6'd12, 6'd13, 6'd35, 6'd43, 6'd48};
    logic [5:0] fnList [0:5]  = '{6'd0, 6'd32, 6'd34, 6'd36, 6'd37, 6'd17};

    initial begin
        logic [5:0] rop, rfn;
        bit stuck;
        int n;
        rst = 1'b1; op = '0; funct = '0; zero = 0; sign = 0; imem_ready = 0; dmem_ready = 0;
        #1;
        checkOutput("reset_outputs",
                    {imem_req, dmem_req, PCWrite, IRWrite, pcsrc, ALUop, ALUsrcA, ALUsrcB,
                     RegDst, ExtSel, datasrc, Regwrite, mWR, halted}, '0);
        checkOutput("reset_count", instr_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0; #1;

        applyStimulus(6'd0,  6'b100000, 0, 0, 0, 0);
        applyStimulus(6'd35, 6'd0,      0, 0, 0, 3);
        applyStimulus(6'd4,  6'd0,      1, 0, 0, 0);
        applyStimulus(6'd4,  6'd0,      0, 0, 1, 0);
        applyStimulus(6'd5,  6'd0,      0, 0, 0, 0);
        applyStimulus(6'd6,  6'd0,      1, 1, 0, 0);
        applyStimulus(6'd2,  6'd0,      0, 0, 0, 0);
        applyStimulus(6'd43, 6'd0,      0, 0, 2, 1);

        for (int i = 0; i < 40; i++) begin
            rop = opList[$urandom_range(0, 13)];
            if ($urandom_range(0, 9) == 0) rop = 6'($urandom);
            if (rop == 6'd63) rop = 6'd48;
            rfn = fnList[$urandom_range(0, 5)];
            applyStimulus(rop, rfn, 1'($urandom), 1'($urandom),
                          $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Halt, then recover with a reset pulse.
        op = 6'b111111; imem_ready = 1'b1; n = 0;
        while (!halted && n < 20) begin @(negedge clk); #1; n++; end
        checkOutput("halt_reached", halted, 1);
        stuck = 0;
        repeat (5) begin
            if (imem_req || PCWrite || IRWrite || Regwrite || dmem_req || !halted) stuck = 1;
            @(negedge clk); #1;
        end
        checkOutput("halt_quiet", stuck, 0);
        checkOutput("halt_count", instr_count, modelCount);
        rst = 1'b1; #1;
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_count", instr_count, 0);
        @(negedge clk); rst = 1'b0; #1;
        modelCount = 0;
        checkOutput("refetch_after_halt", imem_req, 1);

        // Reset while a store waits in MEM.
        op = 6'd43; imem_ready = 1'b1; dmem_ready = 1'b0; n = 0;
        while (!dmem_req && n < 20) begin @(negedge clk); #1; n++; end
        checkOutput("sw_mem_entry", {dmem_req, mWR}, 2'b11);
        rst = 1'b1; #1;
        checkOutput("sw_rst_drop", {dmem_req, mWR}, 2'b00);
        @(negedge clk); rst = 1'b0; #1;
        checkOutput("refetch_after_rst", imem_req, 1);

        applyStimulus(6'b110000, 6'd0, 0, 0, 0, 0);
        applyStimulus(6'd13,     6'd0, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
